// File: rtl/debug_mailbox.sv
// debug_mailbox: bidirectional 16-bit word mailbox between the target core and the debug visor.
// Define MAILBOX_IRQ_EN to add the registered tg_irq output.
module debug_mailbox_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [15:0]   data_i,
    output logic [15:0]   head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          push_ok_o
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    logic [15:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic        pop_ok;
    assign empty_o   = wptr_q == rptr_q;
    assign full_o    = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign pop_ok    = pop_i && !empty_o;
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign push_ok_o = push_i && (!full_o || pop_ok);
    assign count_o   = wptr_q - rptr_q;
    assign head_o    = empty_o ? 16'h0000 : mem_q[rptr_q[AW-1:0]];
    always_comb begin
        wptr_d = push_ok_o ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = pop_ok ? rptr_q + PTR_ONE : rptr_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

module debug_mailbox #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [15:0] tg_wr_data,
    input  logic        tg_wr_load,
    output logic [15:0] tg_rd_data,
    input  logic        tg_rd_ack,
    output logic [15:0] tg_status,
    input  logic        tg_clear_ovf,
`ifdef MAILBOX_IRQ_EN
    output logic        tg_irq,
`endif
    output logic [15:0] vs_rd_data,
    output logic        vs_rd_valid,
    input  logic        vs_rd_ready,
    input  logic [15:0] vs_wr_data,
    input  logic        vs_wr_valid,
    output logic        vs_wr_ready
);
    logic          t2v_empty, t2v_full, t2v_push_ok;
    logic          v2t_empty, v2t_full, v2t_push_ok;
    logic [AW:0]   t2v_count, v2t_count;
    logic          t2v_ovf_q, t2v_ovf_d, v2t_unf_q, v2t_unf_d;
    logic          t2v_ovf_set, v2t_unf_set;

    function automatic logic [3:0] sat4(input logic [AW:0] c);
        logic [4:0] w;
        w = 5'(c);
        return (w > 5'd15) ? 4'hF : w[3:0];
    endfunction

    debug_mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_t2v (
        .clk_i(sysclk), .rst_ni(sysreset),
        .push_i(tg_wr_load), .pop_i(vs_rd_valid && vs_rd_ready), .data_i(tg_wr_data),
        .head_o(vs_rd_data), .empty_o(t2v_empty), .full_o(t2v_full),
        .count_o(t2v_count), .push_ok_o(t2v_push_ok)
    );

    debug_mailbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_v2t (
        .clk_i(sysclk), .rst_ni(sysreset),
        .push_i(vs_wr_valid && vs_wr_ready), .pop_i(tg_rd_ack), .data_i(vs_wr_data),
        .head_o(tg_rd_data), .empty_o(v2t_empty), .full_o(v2t_full),
        .count_o(v2t_count), .push_ok_o(v2t_push_ok)
    );

    assign vs_rd_valid = !t2v_empty;
    // A full v2t still accepts a word when the target pops in the same cycle.
    assign vs_wr_ready = !v2t_full || tg_rd_ack;
    assign t2v_ovf_set = tg_wr_load && !t2v_push_ok;
    assign v2t_unf_set = tg_rd_ack && v2t_empty;
    assign t2v_ovf_d   = t2v_ovf_set || (t2v_ovf_q && !tg_clear_ovf);
    assign v2t_unf_d   = v2t_unf_set || (v2t_unf_q && !tg_clear_ovf);
    assign tg_status   = {sat4(t2v_count), sat4(v2t_count), 2'b00, v2t_unf_q, t2v_ovf_q,
                          t2v_full, t2v_empty, v2t_full, !v2t_empty};

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            t2v_ovf_q <= 1'b0;
            v2t_unf_q <= 1'b0;
        end else begin
            t2v_ovf_q <= t2v_ovf_d;
            v2t_unf_q <= v2t_unf_d;
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d  = (v2t_empty && v2t_push_ok) || (t2v_ovf_set && !t2v_ovf_q);
    assign tg_irq = irq_q;
    always_ff @(posedge sysclk) begin
        if (!sysreset) irq_q <= 1'b0;
        else irq_q <= irq_d;
    end
`endif
endmodule

// File: tb/tb_debug_mailbox.sv
// tb_debug_mailbox: directed checks of the debug mailbox with DEPTH = 4.
module tb_debug_mailbox;
    logic        sysclk = 1'b0;
    logic        sysreset = 1'b0;
    logic [15:0] tg_wr_data = '0;
    logic        tg_wr_load = 1'b0;
    logic [15:0] tg_rd_data;
    logic        tg_rd_ack = 1'b0;
    logic [15:0] tg_status;
    logic        tg_clear_ovf = 1'b0;
    logic [15:0] vs_rd_data;
    logic        vs_rd_valid;
    logic        vs_rd_ready = 1'b0;
    logic [15:0] vs_wr_data = '0;
    logic        vs_wr_valid = 1'b0;
    logic        vs_wr_ready;
`ifdef MAILBOX_IRQ_EN
    logic        tg_irq;
`endif
    int total = 0;
    int bad = 0;

    debug_mailbox #(.DEPTH(4)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .tg_wr_data(tg_wr_data), .tg_wr_load(tg_wr_load),
        .tg_rd_data(tg_rd_data), .tg_rd_ack(tg_rd_ack),
        .tg_status(tg_status), .tg_clear_ovf(tg_clear_ovf),
`ifdef MAILBOX_IRQ_EN
        .tg_irq(tg_irq),
`endif
        .vs_rd_data(vs_rd_data), .vs_rd_valid(vs_rd_valid), .vs_rd_ready(vs_rd_ready),
        .vs_wr_data(vs_wr_data), .vs_wr_valid(vs_wr_valid), .vs_wr_ready(vs_wr_ready)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle;
        tg_wr_load = 0; tg_rd_ack = 0; tg_clear_ovf = 0;
        vs_rd_ready = 0; vs_wr_valid = 0;
    endtask

    task automatic test_reset;
        idle();
        sysreset = 0;
        tg_wr_load = 1; tg_wr_data = 16'hDEAD;
        repeat (3) tick();
        idle();
        sysreset = 1;
        total++; if (tg_status !== 16'h0004) begin bad++; $display("FAIL reset_status got=%h exp=0004", tg_status); end
        total++; if (vs_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", vs_rd_valid); end
        total++; if (vs_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", vs_wr_ready); end
        total++; if (tg_rd_data !== 16'h0000) begin bad++; $display("FAIL reset_tg_rd_data got=%h exp=0000", tg_rd_data); end
        total++; if (vs_rd_data !== 16'h0000) begin bad++; $display("FAIL reset_vs_rd_data got=%h exp=0000", vs_rd_data); end
    endtask

    task automatic test_t2v_order;
        logic [15:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
        vs_rd_ready = 1;
        tg_wr_load = 1;
        for (int i = 0; i < 3; i++) begin
            tg_wr_data = words[i];
            tick();
            total++; if (vs_rd_data !== words[i] || vs_rd_valid !== 1'b1) begin
                bad++; $display("FAIL order_word%0d got=%h valid=%b exp=%h valid=1", i, vs_rd_data, vs_rd_valid, words[i]);
            end
        end
        tg_wr_load = 0;
        tick();
        total++; if (vs_rd_valid !== 1'b0 || vs_rd_data !== 16'h0000) begin
            bad++; $display("FAIL order_drained got valid=%b data=%h exp valid=0 data=0000", vs_rd_valid, vs_rd_data);
        end
        idle();
    endtask

    task automatic test_overflow;
        tg_wr_load = 1;
        for (int i = 0; i < 5; i++) begin
            tg_wr_data = 16'h00A0 + 16'(i);
            tick();
        end
        tg_wr_load = 0;
        total++; if (tg_status !== 16'h4018) begin bad++; $display("FAIL ovf_status got=%h exp=4018", tg_status); end
        vs_rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (vs_rd_data !== 16'h00A0 + 16'(i)) begin
                bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, vs_rd_data, 16'h00A0 + 16'(i));
            end
            tick();
        end
        vs_rd_ready = 0;
        total++; if (vs_rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", vs_rd_valid); end
        total++; if (tg_status !== 16'h0014) begin bad++; $display("FAIL ovf_sticky got=%h exp=0014", tg_status); end
        tg_clear_ovf = 1;
        tick();
        tg_clear_ovf = 0;
        total++; if (tg_status !== 16'h0004) begin bad++; $display("FAIL ovf_clear got=%h exp=0004", tg_status); end
    endtask

    task automatic test_full_simul;
        logic [15:0] exp_seq [4] = '{16'hB001, 16'hB002, 16'hB003, 16'hBEEF};
        vs_wr_valid = 1;
        for (int i = 0; i < 4; i++) begin
            vs_wr_data = 16'hB000 + 16'(i);
            tick();
        end
        vs_wr_valid = 0;
        total++; if (tg_status !== 16'h0407) begin bad++; $display("FAIL full_status got=%h exp=0407", tg_status); end
        total++; if (vs_wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready got=%b exp=0", vs_wr_ready); end
        vs_wr_valid = 1; vs_wr_data = 16'hBEEF; tg_rd_ack = 1;
        #1;
        total++; if (vs_wr_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%b exp=1", vs_wr_ready); end
        tick();
        vs_wr_valid = 0; tg_rd_ack = 0;
        total++; if (tg_status !== 16'h0407) begin bad++; $display("FAIL full_simul_status got=%h exp=0407", tg_status); end
        tg_rd_ack = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (tg_rd_data !== exp_seq[i]) begin
                bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, tg_rd_data, exp_seq[i]);
            end
            tick();
        end
        tg_rd_ack = 0;
        total++; if (tg_status !== 16'h0004) begin bad++; $display("FAIL full_drained got=%h exp=0004", tg_status); end
    endtask

    task automatic test_underflow;
        tg_rd_ack = 1;
        tick();
        tg_rd_ack = 0;
        total++; if (tg_status !== 16'h0024) begin bad++; $display("FAIL unf_status got=%h exp=0024", tg_status); end
        total++; if (tg_rd_data !== 16'h0000) begin bad++; $display("FAIL unf_data got=%h exp=0000", tg_rd_data); end
        tg_rd_ack = 1; tg_clear_ovf = 1;
        tick();
        idle();
        total++; if (tg_status !== 16'h0024) begin bad++; $display("FAIL unf_set_wins got=%h exp=0024", tg_status); end
        tg_clear_ovf = 1;
        tick();
        tg_clear_ovf = 0;
        total++; if (tg_status !== 16'h0004) begin bad++; $display("FAIL unf_clear got=%h exp=0004", tg_status); end
    endtask

    task automatic test_mid_reset;
        tg_wr_load = 1; tg_wr_data = 16'h5555;
        vs_wr_valid = 1; vs_wr_data = 16'h6666;
        repeat (2) tick();
        idle();
        total++; if (tg_status !== 16'h2201) begin bad++; $display("FAIL midrst_pre got=%h exp=2201", tg_status); end
        sysreset = 0;
        tick();
        sysreset = 1;
        total++; if (tg_status !== 16'h0004 || vs_rd_valid !== 1'b0 || tg_rd_data !== 16'h0000) begin
            bad++; $display("FAIL midrst_post got status=%h valid=%b data=%h exp 0004 0 0000", tg_status, vs_rd_valid, tg_rd_data);
        end
    endtask

`ifdef MAILBOX_IRQ_EN
    task automatic test_irq;
        int pulses = 0;
        total++; if (tg_irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", tg_irq); end
        vs_wr_valid = 1; vs_wr_data = 16'h0001;
        tick();
        total++; if (tg_irq !== 1'b1) begin bad++; $display("FAIL irq_pulse got=%b exp=1", tg_irq); end
        vs_wr_data = 16'h0002;
        tick();
        vs_wr_valid = 0;
        total++; if (tg_irq !== 1'b0) begin bad++; $display("FAIL irq_one_cycle got=%b exp=0", tg_irq); end
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(tg_irq);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL irq_extra got=%0d exp=0", pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_t2v_order();
        test_overflow();
        test_full_simul();
        test_underflow();
        test_mid_reset();
`ifdef MAILBOX_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
